// File: rtl/ramp_pkg.sv
// ramp_pkg: shared definitions for the motor soft-start sequencer.
//   - ramp_state_e : sequencer states
//   - LVL_*        : one-hot level codes, bit0=30 %, bit1=50 %, bit2=100 %
//   - DWELL_W      : width of the per-step dwell counter
//   - level_of()   : level code for a given state
package ramp_pkg;

  localparam int DWELL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP30 = 3'd1,
    ST_STEP50 = 3'd2,
    ST_RUN100 = 3'd3,
    ST_DOWN50 = 3'd4,
    ST_DOWN30 = 3'd5,
    ST_FAULT  = 3'd6
  } ramp_state_e;

  localparam logic [2:0] LVL_OFF = 3'b000;
  localparam logic [2:0] LVL_30  = 3'b001;
  localparam logic [2:0] LVL_50  = 3'b010;
  localparam logic [2:0] LVL_100 = 3'b100;

  function automatic logic [2:0] level_of(input ramp_state_e st);
    logic [2:0] lvl;
    lvl = LVL_OFF;
    case (st)
      ST_STEP30, ST_DOWN30: lvl = LVL_30;
      ST_STEP50, ST_DOWN50: lvl = LVL_50;
      ST_RUN100:            lvl = LVL_100;
      default:              lvl = LVL_OFF;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ramp_dwell_counter.sv
// ramp_dwell_counter: counts qualifying ticks spent at one ramp level.
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : zero the count (wins over tick)
//   tick       : step enable from the prescaler
//   limit      : dwell length in ticks (1..15)
//   expire     : combinational, high when this tick is the last one of the dwell
module ramp_dwell_counter
  import ramp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               tick,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // >= rather than == so a count that somehow overshoots still expires.
  assign expire = tick && (cnt_q >= (limit - DWELL_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != {DWELL_W{1'b1}})) begin
      // Saturate at 15 so the count can never wrap back to zero.
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ramp_sequencer.sv
// ramp_sequencer: commanded three-level motor soft start (30/50/100 %).
//   Parameters : FAST_DWELL, SLOW_DWELL - ticks held at each intermediate level
//   Inputs     : clk, reset (async, active high), tick, start_fast, start_slow,
//                stop, fault, fault_clr
//   Outputs    : out_30/out_50/out_100 (one-hot or zero), busy, at_speed,
//                fault_latched, state_dbg (current FSM state for checkers)
//   Build macro: RAMP_SOFT_STOP_EN - stop ramps down through DOWN50/DOWN30
//                instead of dropping straight to IDLE.
// Command priority each cycle: fault > stop > start > tick progress.
// All outputs are registered and decoded from the next state, so a command
// shows on the outputs one clock after it is sampled.
module ramp_sequencer
  import ramp_pkg::*;
#(
  parameter int FAST_DWELL = 1,
  parameter int SLOW_DWELL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_fast,
  input  logic       start_slow,
  input  logic       stop,
  input  logic       fault,
  input  logic       fault_clr,
  output logic       out_30,
  output logic       out_50,
  output logic       out_100,
  output logic       busy,
  output logic       at_speed,
  output logic       fault_latched,
  output logic [2:0] state_dbg
);

  localparam logic [DWELL_W-1:0] FAST_LIM = DWELL_W'(FAST_DWELL);
  localparam logic [DWELL_W-1:0] SLOW_LIM = DWELL_W'(SLOW_DWELL);

  ramp_state_e state_q, state_d;
  logic        mode_q, mode_d;     // 1 = slow ramp, latched on leaving IDLE
  logic [2:0]  lvl_q;
  logic        busy_q, at_speed_q, fault_q;
  logic        cnt_clear, expire;

  ramp_dwell_counter u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .tick   (tick),
    .limit  (mode_q ? SLOW_LIM : FAST_LIM),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // start_slow wins when both requests are present.
          if (start_slow) begin
            state_d = ST_STEP30;
            mode_d  = 1'b1;
          end else if (start_fast) begin
            state_d = ST_STEP30;
            mode_d  = 1'b0;
          end
        end
        ST_STEP30: begin
          if (stop)        state_d = ST_IDLE;
          else if (expire) state_d = ST_STEP50;
        end
        ST_STEP50: begin
`ifdef RAMP_SOFT_STOP_EN
          if (stop)        state_d = ST_DOWN30;
`else
          if (stop)        state_d = ST_IDLE;
`endif
          else if (expire) state_d = ST_RUN100;
        end
        ST_RUN100: begin
`ifdef RAMP_SOFT_STOP_EN
          if (stop) state_d = ST_DOWN50;
`else
          if (stop) state_d = ST_IDLE;
`endif
        end
`ifdef RAMP_SOFT_STOP_EN
        // Ramp-down ignores further stop and start requests.
        ST_DOWN50: if (expire) state_d = ST_DOWN30;
        ST_DOWN30: if (expire) state_d = ST_IDLE;
`endif
        // fault is known low here, so fault_clr alone releases the latch.
        ST_FAULT:  if (fault_clr) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // The dwell count only runs in the timed states and restarts on every
  // state change, so the tick that accompanies a start is never counted.
  always_comb begin
    cnt_clear = (state_d != state_q) ||
                !(state_q inside {ST_STEP30, ST_STEP50, ST_DOWN50, ST_DOWN30});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      lvl_q      <= LVL_OFF;
      busy_q     <= 1'b0;
      at_speed_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lvl_q      <= level_of(state_d);
      busy_q     <= !(state_d inside {ST_IDLE, ST_FAULT});
      at_speed_q <= (state_d == ST_RUN100);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  assign out_30        = lvl_q[0];
  assign out_50        = lvl_q[1];
  assign out_100       = lvl_q[2];
  assign busy          = busy_q;
  assign at_speed      = at_speed_q;
  assign fault_latched = fault_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: directed scenarios plus randomized commands for
// ramp_sequencer. A level-based model (ramp position 0..3, direction, ticks
// elapsed) predicts the output vector each cycle; directed steps also compare
// against hand-computed literal vectors.
module tb_ramp_sequencer;

  localparam int FAST = 1;
  localparam int SLOW = 3;
`ifdef RAMP_SOFT_STOP_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  // Stimulus vector bits
  localparam logic [5:0] T  = 6'b000001;
  localparam logic [5:0] SF = 6'b000010;
  localparam logic [5:0] SS = 6'b000100;
  localparam logic [5:0] SP = 6'b001000;
  localparam logic [5:0] F  = 6'b010000;
  localparam logic [5:0] FC = 6'b100000;

  // Output vector {out_100, out_50, out_30, busy, at_speed, fault_latched}
  localparam logic [5:0] V0   = 6'b000000;
  localparam logic [5:0] V30  = 6'b001100;
  localparam logic [5:0] V50  = 6'b010100;
  localparam logic [5:0] V100 = 6'b100110;
  localparam logic [5:0] VFLT = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, start_fast = 1'b0, start_slow = 1'b0;
  logic stop = 1'b0, fault = 1'b0, fault_clr = 1'b0;
  logic out_30, out_50, out_100, busy, at_speed, fault_latched;
  logic [2:0] state_dbg;
  logic [5:0] dut_vec;

  int checks = 0;
  int errors = 0;

  ramp_sequencer #(.FAST_DWELL(FAST), .SLOW_DWELL(SLOW)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .start_fast    (start_fast),
    .start_slow    (start_slow),
    .stop          (stop),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .out_30        (out_30),
    .out_50        (out_50),
    .out_100       (out_100),
    .busy          (busy),
    .at_speed      (at_speed),
    .fault_latched (fault_latched),
    .state_dbg     (state_dbg)
  );

  assign dut_vec = {out_100, out_50, out_30, busy, at_speed, fault_latched};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_lvl: 0=off, 1=30 %, 2=50 %, 3=100 %; m_up: ramping up (stop honoured)
  int m_lvl = 0;
  int m_ticks = 0;
  bit m_up = 1'b0;
  bit m_slow = 1'b0;
  bit m_flt = 1'b0;
  logic [5:0] exp_q[$];

  function automatic logic [5:0] model_vec();
    logic [5:0] v;
    v    = '0;
    v[5] = (m_lvl == 3);
    v[4] = (m_lvl == 2);
    v[3] = (m_lvl == 1);
    v[2] = !m_flt && (m_lvl != 0);
    v[1] = (m_lvl == 3);
    v[0] = m_flt;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lvl = 0; m_ticks = 0; m_up = 1'b0; m_slow = 1'b0; m_flt = 1'b0;
    end else if (fault) begin
      m_flt = 1'b1; m_lvl = 0;
    end else if (m_flt) begin
      if (fault_clr) m_flt = 1'b0;
    end else if (m_lvl == 0) begin
      if (start_slow || start_fast) begin
        m_lvl = 1; m_up = 1'b1; m_slow = start_slow; m_ticks = 0;
      end
    end else if (stop && m_up) begin
      if (SOFT && m_lvl > 1) begin
        m_lvl = m_lvl - 1; m_up = 1'b0; m_ticks = 0;
      end else begin
        m_lvl = 0;
      end
    end else if (tick && m_lvl != 3) begin
      m_ticks = m_ticks + 1;
      if (m_ticks == (m_slow ? SLOW : FAST)) begin
        m_lvl   = m_up ? m_lvl + 1 : m_lvl - 1;
        m_ticks = 0;
      end
    end
    exp_q.push_back(model_vec());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [5:0] exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q[$];
      exp_q.delete();
      checks++;
      if (dut_vec !== exp_v) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, dut_vec, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [5:0] v);
    @(negedge clk);
    tick = v[0]; start_fast = v[1]; start_slow = v[2];
    stop = v[3]; fault = v[4]; fault_clr = v[5];
    @(posedge clk);
    #1;
  endtask

  // Tick every 4 clocks: three quiet cycles then a tick cycle.
  task automatic run_ticks(input int n);
    repeat (n) begin
      step(6'b0); step(6'b0); step(6'b0); step(T);
    end
  endtask

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp_v);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    #1 chk("reset_state", dut_vec, V0);
    reset = 1'b0;

    // Fast ramp
    step(SF);        chk("fast_out30", dut_vec, V30);
    run_ticks(1);    chk("fast_out50", dut_vec, V50);
    run_ticks(1);    chk("fast_out100", dut_vec, V100);
    chk("model_pin_run100", model_vec(), V100);

    // Async reset mid-RUN100
    @(posedge clk); #3 reset = 1'b1;
    #1 chk("async_reset", dut_vec, V0);
    @(negedge clk); reset = 1'b0;
    step(6'b0);      chk("idle_after_reset", dut_vec, V0);

    // Slow ramp (both starts) then stop
    step(SF | SS);   chk("slow_out30", dut_vec, V30);
    run_ticks(2);    chk("slow_hold30", dut_vec, V30);
    run_ticks(1);    chk("slow_out50", dut_vec, V50);
    run_ticks(3);    chk("slow_out100", dut_vec, V100);
    step(SP);
    if (SOFT) begin
      chk("soft_down50", dut_vec, V50);
      run_ticks(2);  chk("soft_hold50", dut_vec, V50);
      run_ticks(1);  chk("soft_down30", dut_vec, V30);
      run_ticks(3);  chk("soft_idle", dut_vec, V0);
    end else begin
      chk("hard_stop", dut_vec, V0);
    end

    // Fault during STEP50
    step(SF);
    run_ticks(1);    chk("pre_fault50", dut_vec, V50);
    step(F);         chk("fault_entry", dut_vec, VFLT);
    step(F | FC);    chk("fault_clr_blocked", dut_vec, VFLT);
    step(FC);        chk("fault_release", dut_vec, V0);
    chk("model_pin_idle", model_vec(), V0);

    // stop and tick together in STEP30
    step(SF);        chk("st30_again", dut_vec, V30);
    step(SP | T);    chk("stop_beats_tick", dut_vec, V0);

    // Randomized command mix
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] v;
      v    = '0;
      v[0] = ($urandom_range(0, 3) == 0);
      v[1] = ($urandom_range(0, 19) == 0);
      v[2] = ($urandom_range(0, 19) == 0);
      v[3] = ($urandom_range(0, 39) == 0);
      v[4] = ($urandom_range(0, 79) == 0);
      v[5] = ($urandom_range(0, 7) == 0);
      step(v);
    end
    step(6'b0);
    step(6'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ramp_sequencer.md
# ramp_sequencer

Sequences the three-level motor soft-start (30 % / 50 % / 100 %) under start, stop and fault commands, with programmable dwell time per step. It sits between the 1 Hz prescaler (as a single-cycle tick enable) and the motor level outputs, replacing free-running ramp stepping with a commanded, stoppable and fault-safe sequence. All logic runs on the system clock; the tick only gates progress.

## Interface
- FAST_DWELL, 1: ticks spent at each intermediate level in fast mode (1..15)
- SLOW_DWELL, 3: ticks spent at each intermediate level in slow mode (1..15)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle step enable from prescaler
- start_fast  in  1  request fast ramp (level-sensitive, sampled in IDLE)
- start_slow  in  1  request slow ramp (level-sensitive, sampled in IDLE)
- stop  in  1  request stop
- fault  in  1  fault input; forces outputs off
- fault_clr  in  1  clears latched fault
- out_30 / out_50 / out_100  out  1 each  level outputs, one-hot or all zero
- busy  out  1  high in any state except IDLE and FAULT
- at_speed  out  1  high in RUN100
- fault_latched  out  1  high in FAULT

## Operation
- States: IDLE, STEP30, STEP50, RUN100, DOWN50, DOWN30, FAULT.
- Outputs registered, decoded from state: STEP30/DOWN30 -> out_30; STEP50/DOWN50 -> out_50; RUN100 -> out_100; else all zero. Never more than one level high.
- Reset: state IDLE, dwell count 0, mode bit 0; every output 0.
- Priority each cycle: fault > stop > start > tick progress.
- IDLE: start_slow (alone or with start_fast) -> STEP30, mode=slow; start_fast alone -> STEP30, mode=fast. Mode latched until return to IDLE.
- STEP30 -> STEP50 -> RUN100: advance on a tick when dwell count reaches DWELL-1 (DWELL per latched mode); count clears on every state change.
- RUN100: holds until stop or fault; ticks ignored, count held at 0.
- stop in STEP30/STEP50/RUN100: with soft stop (see Configuration) goes to the next-lower DOWN state (RUN100->DOWN50, STEP50->DOWN30, STEP30->IDLE); without it -> IDLE.
- DOWN50 -> DOWN30 -> IDLE using the same dwell rule. Start requests ignored until IDLE. stop in DOWN states has no further effect.
- fault high in any state -> FAULT next edge. FAULT exits to IDLE only when fault_clr=1 and fault=0 in the same cycle; fault_clr with fault=1 is ignored.
- Dwell count 4 bits, saturating guard: never exceeds 15.

## Timing
- Start/stop/fault to output change: 1 clk (registered next edge).
- Tick advance: outputs change on the edge that samples the qualifying tick.
- Tick in the same cycle as a start is not counted; first counted tick is the next one.
- Fast ramp 0->100 %: 2*FAST_DWELL ticks after leaving IDLE; slow: 2*SLOW_DWELL ticks.
- stop and tick in same cycle: stop wins, count cleared.
- Async reset mid-ramp: outputs 0 immediately, no ramp-down.

## Configuration
- RAMP_SOFT_STOP_EN defined: stop ramps down through DOWN50/DOWN30 with dwell as above.
- Not defined: DOWN states are not built; stop from any running state -> IDLE next edge, outputs 0.

## Structure
- Shared package ramp_pkg: state enum, level one-hot constants (LVL_OFF, LVL_30, LVL_50, LVL_100), dwell count width.
- One sub-module: ramp_dwell_counter (clear, tick, limit in; expire out), reused for up and down steps.

## Test plan
- Reset asserted mid-RUN100 -> all outputs 0 same cycle, state IDLE after release.
- start_fast pulse, FAST_DWELL=1, tick every 4 clk -> out_30 next clk, out_50 after 1st tick, out_100 after 2nd tick, at_speed=1.
- start_fast and start_slow together, SLOW_DWELL=3 -> out_50 only after 3rd tick, out_100 after 6th.
- RUN100 then stop with RAMP_SOFT_STOP_EN, slow mode -> out_50 next clk, out_30 after 3 ticks, all 0 after 6 ticks; without macro -> all 0 next clk.
- fault during STEP50 -> outputs 0, fault_latched=1 next clk; fault_clr while fault=1 -> stays FAULT; fault=0 with fault_clr -> IDLE.
- stop and tick same cycle in STEP30 (soft stop) -> IDLE, out_30 drops, no advance to out_50.
